debug_sender: RTL and testbench

Transmit side of the debug UART link. When the debug controller raises `send_flag` after a step or a halt, this block dumps the halted processor's state to the UART transmitter one byte at a time: PC, cycle counter, the full register file, then the first `DM_DEPTH` data-memory words. It drives the register-file and data-memory debug read ports. When the last byte is acknowledged, it returns `send_done` to the controller.

---
 rtl/debug_sender.sv | 176 +++++++++++++++++
 tb/tb_debug_sender.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_sender.sv
// debug_sender: streams the halted processor's state (PC, cycle counter,
// register file, first DM_DEPTH data-memory words) to the debug UART
// transmitter one byte at a time, MSB byte of each word first.
module debug_sender #(
  parameter int NBITS     = 32,
  parameter int NREGS     = 32,
  parameter int RF_ADDR_W = 5,
  parameter int DM_DEPTH  = 32,
  parameter int DM_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send_flag,
  input  logic [NBITS-1:0]     pc_value,
  input  logic [NBITS-1:0]     cycle_count,
  input  logic [NBITS-1:0]     rf_data,
  input  logic [NBITS-1:0]     dm_data,
  input  logic                 tx_done,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  output logic [RF_ADDR_W-1:0] rf_addr,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic                 send_done,
  output logic                 busy
);

  // Frame geometry: PC, cycle counter, register file, data memory.
  localparam int WORDS = 2 + NREGS + DM_DEPTH;
  localparam int WW    = $clog2(WORDS + 1);

  localparam logic [WW-1:0] LAST_W   = WW'(WORDS - 1);
  localparam logic [WW-1:0] RF_FIRST = WW'(2);
  localparam logic [WW-1:0] DM_FIRST = WW'(2 + NREGS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_RELEASE = 3'd6;

  logic [2:0]       state, state_next;
  logic [WW-1:0]    w, w_next;
  logic [1:0]       b, b_next;
  logic [NBITS-1:0] shift, shift_next;

  // Register-file read address for word index wi (0 outside the RF range).
  function automatic logic [RF_ADDR_W-1:0] rf_addr_of(input logic [WW-1:0] wi);
    if (wi >= RF_FIRST && wi < DM_FIRST) begin
      rf_addr_of = RF_ADDR_W'(wi - RF_FIRST);
    end else begin
      rf_addr_of = '0;
    end
  endfunction

  // Data-memory read address for word index wi (0 outside the DM range).
  function automatic logic [DM_ADDR_W-1:0] dm_addr_of(input logic [WW-1:0] wi);
    if (wi >= DM_FIRST) begin
      dm_addr_of = DM_ADDR_W'(wi - DM_FIRST);
    end else begin
      dm_addr_of = '0;
    end
  endfunction

  // Next-state, word/byte counter and shift-register logic.
  always_comb begin
    state_next = state;
    w_next     = w;
    b_next     = b;
    shift_next = shift;
    case (state)
      S_IDLE: begin
        if (send_flag) begin
          state_next = S_FETCH;
          w_next     = '0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        state_next = S_LOAD;
      end
      S_LOAD: begin
        if (w == '0) begin
          shift_next = pc_value;
        end else if (w == WW'(1)) begin
          shift_next = cycle_count;
        end else if (w < DM_FIRST) begin
          shift_next = rf_data;
        end else begin
          shift_next = dm_data;
        end
        b_next     = 2'd0;
        state_next = S_SEND;
      end
      S_SEND: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_done) begin
          state_next = S_WAIT;
        end else if (b != 2'd3) begin
          shift_next = {shift[NBITS-9:0], 8'h00};
          b_next     = b + 2'd1;
          state_next = S_SEND;
        end else if (w != LAST_W) begin
          w_next     = w + WW'(1);
          state_next = S_FETCH;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_RELEASE;
      end
      S_RELEASE: begin
        // Hold here until the controller drops its level request so the
        // still-high flag cannot start a second dump.
        if (!send_flag) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_RELEASE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      w     <= '0;
      b     <= 2'd0;
      shift <= '0;
    end else begin
      state <= state_next;
      w     <= w_next;
      b     <= b_next;
      shift <= shift_next;
    end
  end

  // Outputs are registered from the next-state values so that every output
  // lines up with the state it belongs to while coming straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start  <= 1'b0;
      tx_byte   <= 8'h00;
      rf_addr   <= '0;
      dm_addr   <= '0;
      send_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tx_start  <= (state_next == S_SEND);
      send_done <= (state_next == S_DONE);
      busy      <= (state_next != S_IDLE);
      if (state_next == S_SEND) begin
        tx_byte <= shift_next[NBITS-1 -: 8];
      end else begin
        tx_byte <= tx_byte;
      end
      if (state_next == S_FETCH) begin
        rf_addr <= rf_addr_of(w_next);
        dm_addr <= dm_addr_of(w_next);
      end else begin
        rf_addr <= rf_addr;
        dm_addr <= dm_addr;
      end
    end
  end

endmodule

// File: tb/tb_debug_sender.sv
// Self-checking bench for debug_sender: default geometry instance plus a
// small NREGS=4 / DM_DEPTH=1 instance, with memory and UART models.
module tb_debug_sender;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send_flag = 1'b0;
  logic        tx_done_drv = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] pc_value = 32'h0;
  logic [31:0] cycle_count = 32'h0;

  logic [31:0] rf_data_a, dm_data_a, rf_data_b, dm_data_b;
  logic        ts_a, sd_a, busy_a, ts_b, sd_b, busy_b;
  logic [7:0]  tb_a, tb_b;
  logic [4:0]  rf_a, dm_a, rf_b, dm_b;

  logic        flag_a, flag_b, done_a, done_b;
  logic        ts_m, sd_m, busy_m;
  logic [7:0]  tb_m;
  logic [4:0]  rf_m, dm_m;

  int checks = 0;
  int passes = 0;
  logic [7:0] cap [0:263];

  always #5 clk = ~clk;

  assign flag_a = send_flag & ~sel;
  assign flag_b = send_flag & sel;
  assign done_a = tx_done_drv & ~sel;
  assign done_b = tx_done_drv & sel;
  assign ts_m   = sel ? ts_b   : ts_a;
  assign sd_m   = sel ? sd_b   : sd_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign tb_m   = sel ? tb_b   : tb_a;
  assign rf_m   = sel ? rf_b   : rf_a;
  assign dm_m   = sel ? dm_b   : dm_a;

  // Synchronous-read memory models: rf[i] = i, dm[j] = 0xA0000000 + j.
  always @(posedge clk) begin
    rf_data_a <= {27'd0, rf_a};
    dm_data_a <= 32'hA000_0000 + {27'd0, dm_a};
    rf_data_b <= {27'd0, rf_b};
    dm_data_b <= 32'hA000_0000 + {27'd0, dm_b};
  end

  debug_sender dut_a (
    .clk(clk), .reset(reset), .send_flag(flag_a), .pc_value(pc_value),
    .cycle_count(cycle_count), .rf_data(rf_data_a), .dm_data(dm_data_a),
    .tx_done(done_a), .tx_start(ts_a), .tx_byte(tb_a), .rf_addr(rf_a),
    .dm_addr(dm_a), .send_done(sd_a), .busy(busy_a)
  );

  debug_sender #(.NREGS(4), .DM_DEPTH(1)) dut_b (
    .clk(clk), .reset(reset), .send_flag(flag_b), .pc_value(pc_value),
    .cycle_count(cycle_count), .rf_data(rf_data_b), .dm_data(dm_data_b),
    .tx_done(done_b), .tx_start(ts_b), .tx_byte(tb_b), .rf_addr(rf_b),
    .dm_addr(dm_b), .send_done(sd_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_word(input int wd, input int nregs);
    if (wd == 0) return pc_value;
    else if (wd == 1) return cycle_count;
    else if (wd < 2 + nregs) return 32'(wd - 2);
    else return 32'hA000_0000 + 32'(wd - 2 - nregs);
  endfunction

  function automatic logic [7:0] exp_byte(input int n, input int nregs);
    logic [31:0] wv;
    wv = exp_word(n / 4, nregs);
    return wv[31 - 8 * (n % 4) -: 8];
  endfunction

  function automatic logic [4:0] exp_rf(input int wd, input int nregs);
    return (wd >= 2 && wd < 2 + nregs) ? 5'(wd - 2) : 5'd0;
  endfunction

  function automatic logic [4:0] exp_dm(input int wd, input int nregs);
    return (wd >= 2 + nregs) ? 5'(wd - 2 - nregs) : 5'd0;
  endfunction

  // Runs one frame on the selected DUT with a UART model answering each
  // tx_start with tx_done 10 cycles later. Cycle 0 is the cycle in which
  // send_flag is first high.
  task automatic run_frame(input int nregs, input int ndm, input int drop_at,
                           input bit spurious, input int hold_after, input int abort_at);
    int c, due, done_c, fetch_c, dc, nb, nd, exp_bytes, lat;
    int gap_err, addr_err, byte_err, wd;
    bit stop, rel_ok;
    logic [7:0] eb;
    exp_bytes = 4 * (2 + nregs + ndm);
    c = 0; due = -1; done_c = -100; fetch_c = 1; dc = -1; nb = 0; nd = 0; lat = -1;
    gap_err = 0; addr_err = 0; byte_err = 0; stop = 1'b0; rel_ok = 1'b1;
    @(negedge clk);
    send_flag = 1'b1;
    tx_done_drv = 1'b0;
    while (!stop && c < 6000) begin
      @(negedge clk);
      c++;
      tx_done_drv = 1'b0;
      if (ts_m) begin
        if (nb == 0) lat = c;
        else if (c - done_c != ((nb % 4 == 0) ? 3 : 1)) gap_err++;
        eb = exp_byte(nb, nregs);
        if (nb < 264) cap[nb] = tb_m;
        if (tb_m !== eb) byte_err++;
        nb++;
        due = c + 10;
        if (spurious && (nb % 5 == 0)) tx_done_drv = 1'b1;
        if (nb == drop_at) send_flag = 1'b0;
      end else if (c == due) begin
        tx_done_drv = 1'b1;
        done_c = c;
        if (nb % 4 == 0 && nb < exp_bytes) fetch_c = c + 1;
      end else if (c == fetch_c) begin
        wd = nb / 4;
        if (rf_m !== exp_rf(wd, nregs) || dm_m !== exp_dm(wd, nregs)) addr_err++;
        if (spurious) tx_done_drv = 1'b1;
      end
      if (sd_m) begin
        nd++;
        if (dc < 0) dc = c;
      end
      if (dc >= 0 && c == dc + hold_after) begin
        if (send_flag && busy_m !== 1'b1) rel_ok = 1'b0;
        send_flag = 1'b0;
      end
      if (dc >= 0 && c >= dc + hold_after + 3) stop = 1'b1;
      if (abort_at > 0 && nb == abort_at && c == due - 3) stop = 1'b1;
    end
    if (abort_at > 0) begin
      check("abort_point_reached", 32'(stop), 32'd1);
    end else begin
      check("first_tx_start_latency", 32'(lat), 32'd3);
      check("byte_gap_errors", 32'(gap_err), 32'd0);
      check("fetch_addr_errors", 32'(addr_err), 32'd0);
      check("frame_byte_errors", 32'(byte_err), 32'd0);
      check("tx_start_count", 32'(nb), 32'(exp_bytes));
      check("send_done_count", 32'(nd), 32'd1);
      check("send_done_latency", 32'(dc - done_c), 32'd1);
      check("release_busy", 32'(rel_ok), 32'd1);
      check("idle_after_frame", 32'(busy_m), 32'd0);
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } byte_vec_t;

  initial begin
    byte_vec_t vecs [0:10];
    vecs[0]  = '{0,   8'h00};
    vecs[1]  = '{3,   8'h40};
    vecs[2]  = '{6,   8'h01};
    vecs[3]  = '{7,   8'h2C};
    vecs[4]  = '{11,  8'h00};
    vecs[5]  = '{15,  8'h01};
    vecs[6]  = '{135, 8'h1F};
    vecs[7]  = '{136, 8'hA0};
    vecs[8]  = '{139, 8'h00};
    vecs[9]  = '{260, 8'hA0};
    vecs[10] = '{263, 8'h1F};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(ts_a), 32'd0);
    check("rst_tx_byte", 32'(tb_a), 32'd0);
    check("rst_rf_addr", 32'(rf_a), 32'd0);
    check("rst_dm_addr", 32'(dm_a), 32'd0);
    check("rst_send_done", 32'(sd_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    reset = 1'b0;

    // Stray tx_done while idle does nothing.
    @(negedge clk);
    tx_done_drv = 1'b1;
    @(negedge clk);
    tx_done_drv = 1'b0;
    @(negedge clk);
    check("idle_spurious_busy", 32'(busy_a), 32'd0);
    check("idle_spurious_tx_start", 32'(ts_a), 32'd0);

    // Reset asserted while waiting on a byte of word 5.
    pc_value = 32'h0000_0040;
    cycle_count = 32'h0000_012C;
    run_frame(32, 32, 0, 1'b0, 0, 22);
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    send_flag = 1'b0;
    #1;
    check("mid_rst_tx_start", 32'(ts_a), 32'd0);
    check("mid_rst_tx_byte", 32'(tb_a), 32'd0);
    check("mid_rst_addrs", {22'd0, rf_a, dm_a}, 32'd0);
    check("mid_rst_send_done", 32'(sd_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_stays_idle", 32'(busy_a), 32'd0);

    // Basic dump, restarting from the PC.
    run_frame(32, 32, 0, 1'b0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("basic_byte_%0d", vecs[i].idx), 32'(cap[vecs[i].idx]), 32'(vecs[i].exp));
    end

    // Spurious tx_done in SEND/FETCH and send_flag dropped at byte 100.
    pc_value = 32'hDEAD_BEEF;
    cycle_count = 32'h0123_4567;
    run_frame(32, 32, 100, 1'b1, 0, 0);
    check("robust_pc_msb", 32'(cap[0]), 32'h0000_00DE);

    // Flag held 5 cycles after send_done, then a re-raise gives a new frame.
    run_frame(32, 32, 0, 1'b0, 5, 0);
    run_frame(32, 32, 0, 1'b0, 0, 0);

    // Small geometry: 7 words, 28 bytes.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(4, 1, 0, 1'b0, 0, 0);
    check("corner_last_word_b0", 32'(cap[24]), 32'h0000_00A0);
    check("corner_last_word_b3", 32'(cap[27]), 32'h0000_0000);
    check("corner_dm_addr_last", 32'(dm_b), 32'd0);
    check("corner_rf_addr_last", 32'(rf_b), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
